// File: rtl/mem_pkg.sv
// mem_pkg -- shared types and helpers for the on-chip data-memory responder.
//
// Contents:
//   dmem_state_e        responder FSM states (IDLE, WAIT, RESP)
//   DMEM_IDX_W(depth)   word-index width for an array of `depth` words
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    function automatic int DMEM_IDX_W(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// dmem_sram_array -- word-organised SRAM with one synchronous read port and
// one byte-strobed write port, written so that it maps onto a block RAM.
//
// Ports:
//   clk      clock, all activity on its rising edge
//   re       read enable; rdata_q loads mem[ridx] at the edge
//   ridx     read word index
//   rdata_q  registered read data (holds between reads)
//   we       write enable
//   widx     write word index
//   wdata    write data, lane-aligned
//   wstrb    byte enables, bit i covers wdata[8i+7:8i]
module dmem_sram_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                                clk,
    input  logic                                re,
    input  logic [DMEM_IDX_W(DEPTH_WORDS)-1:0]  ridx,
    output logic [31:0]                         rdata_q,
    input  logic                                we,
    input  logic [DMEM_IDX_W(DEPTH_WORDS)-1:0]  widx,
    input  logic [31:0]                         wdata,
    input  logic [3:0]                          wstrb
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[ridx];
        end
    end

endmodule

// File: rtl/dmem_sram_resp.sv
// dmem_sram_resp -- target end of the core's dmem_* request/response
// interface in front of a word-organised SRAM. Answers word-aligned reads and
// byte-strobed writes after WAIT_STATES extra cycles, flags out-of-range
// accesses with dmem_err.
//
// Handshake: the initiator raises dmem_valid and holds it plus every request
// field stable until it sees dmem_ready; a transfer completes in the single
// cycle where dmem_valid & dmem_ready. Dropping dmem_valid before that aborts
// the request (no write, no response).
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   dmem_valid   request valid (in)
//   dmem_ready   one-cycle response strobe (out)
//   dmem_addr    byte address, bits [1:0] ignored (in)
//   dmem_write   1 = write, 0 = read (in)
//   dmem_wdata   lane-aligned write data (in)
//   dmem_wstrb   byte enables (in)
//   dmem_rdata   read data, meaningful while dmem_ready (out)
//   dmem_err     out-of-range access, meaningful while dmem_ready (out)
//   dbg_state    current FSM state for observation (out)
module dmem_sram_resp
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_valid,
    output logic        dmem_ready,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_write,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output dmem_state_e dbg_state
);

    localparam int          IDX_W      = DMEM_IDX_W(DEPTH_WORDS);
    localparam logic [32:0] SIZE_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rng_q;       // in-range flag of the access being answered
    logic [31:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             to_resp;     // this cycle is the last one before RESP
    logic             arr_re;
    logic             arr_we;
    logic [31:0]      arr_rdata;

    // 32-bit wrap makes addresses below BASE_ADDR land far out of range.
    assign off      = dmem_addr - BASE_ADDR;
    assign in_range = {1'b0, off} < SIZE_BYTES;
    assign idx      = off[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dmem_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        to_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!dmem_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    to_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (to_resp) begin
                rng_q <= in_range;
            end
        end
    end

    // Read in the cycle before RESP so the data sits in rdata_q during RESP.
    // The write lands on the edge that ends RESP, so a following read of the
    // same word (which cannot start before the next IDLE cycle) sees it.
    // Reset forces state to IDLE asynchronously, so an aborted RESP never
    // produces arr_we on the following edge.
    assign arr_re = to_resp & ~dmem_write & in_range;
    assign arr_we = (state_q == RESP) & dmem_valid & dmem_write & rng_q;

    dmem_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .re      (arr_re),
        .ridx    (idx),
        .rdata_q (arr_rdata),
        .we      (arr_we),
        .widx    (idx),
        .wdata   (dmem_wdata),
        .wstrb   (dmem_wstrb)
    );

    // Both operands are registers, so rdata has no path from the inputs. The
    // cleared rng_q gives 0 after reset and for out-of-range reads without
    // needing a reset on the RAM output register.
    assign dmem_rdata = rng_q ? arr_rdata : 32'h0;
    assign dmem_ready = (state_q == RESP) & dmem_valid;
    assign dmem_err   = dmem_ready & ~rng_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_sram_resp.sv
// tb_dmem_sram_resp -- bench for dmem_sram_resp. Three instances share clock
// and reset and differ only in WAIT_STATES (0, 3, 4). A word-level memory
// model (associative array) plus a response-cycle prediction per instance is
// compared against the DUT every falling edge; directed sequences add
// literal expectations on data, error and latency.
module tb_dmem_sram_resp;
    import mem_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          NW   = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid [3];
    logic        write [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic        ready [3];
    logic        err   [3];
    logic [31:0] rdata [3];
    dmem_state_e st    [3];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_rdy_cyc [3];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_sram_resp #(
            .BASE_ADDR   (BASE),
            .DEPTH_WORDS (NW),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .dmem_valid (valid[g]),
            .dmem_ready (ready[g]),
            .dmem_addr  (addr[g]),
            .dmem_write (write[g]),
            .dmem_wdata (wdata[g]),
            .dmem_wstrb (wstrb[g]),
            .dmem_rdata (rdata[g]),
            .dmem_err   (err[g]),
            .dbg_state  (st[g])
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic [31:0] c_off, c_word;
    logic        c_inr, c_exp_rdy;
    int          c_key;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                c_off     = addr[i] - BASE;
                c_inr     = (c_off < 32'(NW * 4));
                c_key     = i * NW + int'(c_off[13:2]);
                c_exp_rdy = valid[i] && (cyc == exp_rdy_cyc[i]);
                chk($sformatf("ready_u%0d_c%0d", i, cyc), 32'(ready[i]), 32'(c_exp_rdy));
                if (c_exp_rdy && ready[i]) begin
                    chk($sformatf("err_u%0d_%h", i, addr[i]), 32'(err[i]), 32'(!c_inr));
                    if (!write[i]) begin
                        if (!c_inr)
                            chk($sformatf("rdata_oor_u%0d", i), rdata[i], 32'h0);
                        else if (mdl.exists(c_key))
                            chk($sformatf("rdata_u%0d_%h", i, addr[i]), rdata[i], mdl[c_key]);
                    end else if (c_inr) begin
                        c_word = mdl.exists(c_key) ? mdl[c_key] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (wstrb[i][b]) c_word[8*b +: 8] = wdata[i][8*b +: 8];
                        mdl[c_key] = c_word;
                    end
                    exp_rdy_cyc[i] = -1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns one time unit after the
    // edge that follows the response, with valid already low.
    task automatic do_req(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er, output int lat);
        int t0;
        bit got;
        valid[i] = 1'b1; write[i] = w; addr[i] = a; wdata[i] = d; wstrb[i] = s;
        t0 = cyc;
        exp_rdy_cyc[i] = cyc + 1 + ws_of(i);
        got = 1'b0; rd = '0; er = 1'b0; lat = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ready[i]) begin
                got = 1'b1; rd = rdata[i]; er = err[i]; lat = cyc - t0;
            end
        end
        chk($sformatf("ready_seen_u%0d_%h", i, a), 32'(got), 32'd1);
        @(posedge clk); #1;
        valid[i] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0; write[i] = 1'b0; addr[i] = BASE;
            wdata[i] = '0; wstrb[i] = '0; exp_rdy_cyc[i] = -1;
        end
        idle(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready_u%0d", i), 32'(ready[i]), 32'd0);
            chk($sformatf("rst_rdata_u%0d", i), rdata[i], 32'd0);
            chk($sformatf("rst_state_u%0d", i), 32'(st[i]), 32'(IDLE));
        end
        rst = 1'b0;
        idle(1);

        // WAIT_STATES=0: write then back-to-back read of the same word
        do_req(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("wr_lat_ws0", 32'(lat), 32'd1);
        chk("wr_err_ws0", 32'(er), 32'd0);
        do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        chk("raw_rdata_ws0", rd, 32'hDEAD_BEEF);
        chk("rd_lat_ws0", 32'(lat), 32'd1);

        // byte strobes, and an all-zero strobe that must change nothing
        idle(1);
        do_req(0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
        do_req(0, 1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, rd, er, lat);
        do_req(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
        chk("strb_rdata", rd, 32'h1122_AA44);
        do_req(0, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
        chk("strb0_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 32'h8000_0022, 32'h0, 4'h0, rd, er, lat);
        chk("strb0_rdata", rd, 32'h1122_AA44);

        // WAIT_STATES=3 latency
        do_req(1, 1'b1, 32'h8000_0010, 32'hA5A5_5A5A, 4'hF, rd, er, lat);
        chk("wr_lat_ws3", 32'(lat), 32'd4);
        idle(2);
        do_req(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        chk("rd_lat_ws3", 32'(lat), 32'd4);
        chk("rd_rdata_ws3", rd, 32'hA5A5_5A5A);

        // out-of-range accesses around the window edges
        do_req(0, 1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, rd, er, lat);
        do_req(0, 1'b1, 32'h8000_3FFC, 32'hF0E0_D0C0, 4'hF, rd, er, lat);
        chk("last_word_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 32'h8000_4000, 32'h0, 4'h0, rd, er, lat);
        chk("oor_rd_err", 32'(er), 32'd1);
        chk("oor_rd_rdata", rd, 32'h0);
        do_req(0, 1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, rd, er, lat);
        chk("oor_wr_err", 32'(er), 32'd1);
        do_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        chk("oor_word0", rd, 32'h0102_0304);
        do_req(0, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er, lat);
        chk("oor_wordlast", rd, 32'hF0E0_D0C0);

        // WAIT_STATES=4: valid dropped during WAIT
        do_req(2, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        chk("wr_lat_ws4", 32'(lat), 32'd5);
        idle(1);
        valid[2] = 1'b1; write[2] = 1'b1; addr[2] = 32'h8000_0000;
        wdata[2] = 32'h1234_5678; wstrb[2] = 4'hF;
        exp_rdy_cyc[2] = cyc + 5;
        idle(2);
        chk("abort_in_wait", 32'(st[2]), 32'(WAIT));
        valid[2] = 1'b0;
        exp_rdy_cyc[2] = -1;
        idle(1);
        chk("abort_state", 32'(st[2]), 32'(IDLE));
        idle(6);
        do_req(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        chk("abort_rdata", rd, 32'hCAFE_F00D);

        // reset asserted during RESP of a write
        do_req(0, 1'b1, 32'h8000_0040, 32'h0BAD_C0DE, 4'hF, rd, er, lat);
        do_req(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
        chk("pre_rst_rdata", rd, 32'h0BAD_C0DE);
        idle(1);
        valid[0] = 1'b1; write[0] = 1'b1; addr[0] = 32'h8000_0040;
        wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF;
        exp_rdy_cyc[0] = cyc + 1;
        @(posedge clk); #1;
        chk("resp_before_rst", 32'(ready[0]), 32'd1);
        #1;
        rst = 1'b1;
        valid[0] = 1'b0;
        exp_rdy_cyc[0] = -1;
        #1;
        chk("rst_mid_ready", 32'(ready[0]), 32'd0);
        chk("rst_mid_err", 32'(err[0]), 32'd0);
        chk("rst_mid_rdata", rdata[0], 32'd0);
        chk("rst_mid_state", 32'(st[0]), 32'(IDLE));
        idle(1);
        rst = 1'b0;
        idle(1);
        do_req(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
        chk("rst_no_write", rd, 32'h0BAD_C0DE);

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule

// File: doc/dmem_sram_resp.md
# dmem_sram_resp

On-chip data-memory responder for the core's D-mem request/response interface: the target end of the `dmem_*` handshake driven by the core memory stage. Sits between the core and a word-organised SRAM, answering word-aligned reads and byte-strobed writes after a programmable number of wait states. Flags out-of-range accesses with `dmem_err`, which the core turns into load/store access faults.

## Interface
Parameters:
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0; must be 4B-aligned.
- `DEPTH_WORDS`, 4096, number of 32-bit words; power of two, ≥ 2.
- `WAIT_STATES`, 0, extra cycles inserted before `dmem_ready`; range 0..15.

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `dmem_valid`, in, 1, request valid; the initiator holds it and all request fields stable until `dmem_ready`.
- `dmem_ready`, out, 1, response cycle; the handshake completes when `dmem_valid & dmem_ready`.
- `dmem_addr`, in, 32, byte address; bits [1:0] ignored.
- `dmem_write`, in, 1, 1 = write, 0 = read.
- `dmem_wdata`, in, 32, write data, already lane-aligned.
- `dmem_wstrb`, in, 4, byte enables; bit i enables byte lane [8i+7:8i].
- `dmem_rdata`, out, 32, read data; meaningful only while `dmem_ready`.
- `dmem_err`, out, 1, access error; meaningful only while `dmem_ready`.

## Operation
- Offset: `off = dmem_addr - BASE_ADDR`, computed with 32-bit unsigned wrap.
- In range: `off < DEPTH_WORDS*4`.
- Word index: `idx = off[log2(DEPTH_WORDS)+1:2]`.
- The FSM has three states: IDLE, WAIT and RESP.
  - IDLE: on `dmem_valid` go to WAIT if `WAIT_STATES > 0`, else go to RESP. Load `cnt` with `WAIT_STATES-1`.
  - WAIT: `cnt` decrements each cycle. When `cnt == 0`, go to RESP.
  - RESP: assert `dmem_ready` for exactly one cycle, then return to IDLE unconditionally.
- Read path:
  - The array is read synchronously in the cycle before RESP, either the last IDLE cycle or the last WAIT cycle.
  - The result is registered into `dmem_rdata`.
  - An out-of-range read loads `dmem_rdata` with 0.
- Write path: the array is updated at the rising edge that ends RESP, only if in range, only the enabled lanes.
  - `dmem_wstrb == 0` writes nothing and raises no error.
- Error: `dmem_err = dmem_ready & ~in_range`. An out-of-range write leaves the array untouched.
- Protocol violation: if `dmem_valid` drops in WAIT or RESP, return to IDLE immediately.
  - No write occurs.
  - `dmem_ready` deasserts in that same cycle; it is gated by `dmem_valid`.
- Reset:
  - `dmem_ready = 0`, `dmem_err = 0`, `dmem_rdata = 0`, `cnt = 0`, state = IDLE.
  - Array contents are not reset.
  - A reset asserted mid-request aborts the request with no write.

## Timing
- Request first seen in IDLE at cycle T → `dmem_ready` asserted in cycle T+1+WAIT_STATES.
- Back-to-back requests: at least one IDLE cycle between responses, so one access per WAIT_STATES+2 cycles.
- Read-after-write to the same word on consecutive requests returns the new data. The write commits at the end of RESP, before the next array read.
- `dmem_ready` and `dmem_err` are driven from registered state ANDed with `dmem_valid`. There is no other combinational path from inputs to outputs.
- `dmem_rdata` is driven directly from a register.

## Structure
- Shared package `mem_pkg`:
  - `dmem_state_e` enum (IDLE, WAIT, RESP).
  - Width constant `DMEM_IDX_W(DEPTH)` as a function.
- Sub-module `dmem_sram_array`:
  - Parameterised by DEPTH_WORDS.
  - Ports: `clk`, `re`, `ridx`, `rdata_q`, `we`, `widx`, `wdata`, `wstrb`.
  - One synchronous read port and one byte-write port; inferable as block RAM.
- The top level holds the FSM, counter, range decode and output gating.

## Test plan
- WAIT_STATES=0: write `0xDEADBEEF`, wstrb=`4'hF`, to `0x8000_0010`; then read the same address.
  - Write: `dmem_ready` at T+1, `dmem_err=0`.
  - Read: `dmem_rdata=0xDEADBEEF` at T+1.
- Byte strobes:
  - First write `0x11223344` with wstrb `4'hF` to `0x8000_0020`.
  - Then write `0x0000AA00` with wstrb `4'b0010` to the same address.
  - Read back → `0x1122AA44`.
- WAIT_STATES=3: a read is first seen at cycle 10 → `dmem_ready` high only at cycle 14, for exactly one cycle.
- Out-of-range accesses, DEPTH_WORDS=4096:
  - Read of `0x8000_4000` → `dmem_err=1`, `dmem_rdata=0`.
  - Write of `0x7FFF_FFFC` → `dmem_err=1`, and the array is unchanged (check word 0 and the last word).
- Abort:
  - WAIT_STATES=4, a write to `0x8000_0000` with `dmem_valid` dropped in WAIT → no `dmem_ready`, FSM back in IDLE; a later read returns the old data.
  - Separately, assert `rst` during RESP → outputs 0 immediately and no write.
